// File: rtl/qupls_agen_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : qupls_agen_pipe_if
//  Description : Station-side operand bus and LSQ/DTLB-side beat bus of the
//                address-generation execute stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface qupls_agen_pipe_if #(
  parameter int AWID = 64,
  parameter int IDW  = 5
);
  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  logic [IDW-1:0]  id_i;
  logic [AWID-1:0] argA_i;
  logic [AWID-1:0] argB_i;
  logic [AWID-1:0] argI_i;
  logic [1:0]      scale_i;
  logic [2:0]      size_i;
  logic            store_i;
  logic            excv_i;
  logic            valid_o;
  logic            ready_i;
  logic [IDW-1:0]  id_o;
  logic [AWID-1:0] adr_o;
  logic [4:0]      len_o;
  logic            store_o;
  logic            split_o;
  logic            last_o;
  logic            excv_o;

  // Environment side: drives ops, flush and beat acceptance.
  modport master (
    output flush_i, valid_i, id_i, argA_i, argB_i, argI_i, scale_i, size_i,
           store_i, excv_i, ready_i,
    input  ready_o, valid_o, id_o, adr_o, len_o, store_o, split_o, last_o, excv_o
  );

  // Address-generation stage side.
  modport slave (
    input  flush_i, valid_i, id_i, argA_i, argB_i, argI_i, scale_i, size_i,
           store_i, excv_i, ready_i,
    output ready_o, valid_o, id_o, adr_o, len_o, store_o, split_o, last_o, excv_o
  );
endinterface
`default_nettype wire

// File: rtl/qupls_agen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : qupls_agen_pipe
//  Description : Address-generation execute stage. Computes
//                EA = argA + (argB << scale) + argI and issues one registered
//                access beat, or two beats when the access crosses a page.
//  Revision    : 1.0  initial release
// ============================================================================
module qupls_agen_pipe #(
  parameter int AWID   = 64,
  parameter int IDW    = 5,
  parameter int PGBITS = 12
) (
  input  wire logic               clk,
  input  wire logic               rst,
  qupls_agen_pipe_if.slave        ab
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  localparam logic [PGBITS:0]  c_PGSIZE = {1'b1, {PGBITS{1'b0}}};
  localparam logic [AWID-1:0]  c_PGMASK = {{(AWID-PGBITS){1'b0}}, {PGBITS{1'b1}}};
  localparam int               c_PGW    = PGBITS + 1;

  state_t          r_state;
  logic [AWID-1:0] r_adr1;
  logic [4:0]      r_len1;

  logic [AWID-1:0] w_ea;
  logic            w_illegal;
  logic            w_exc;
  logic [4:0]      w_bytes;
  logic [PGBITS:0] w_pgSum;
  logic            w_cross;
  logic [4:0]      w_len0;
  logic            w_accept;

  // Effective address, byte count and page-crossing detection.
  always_comb begin
    w_ea      = ab.argA_i + (ab.argB_i << ab.scale_i) + ab.argI_i;
    w_illegal = (ab.size_i > 3'd4);
    w_exc     = ab.excv_i | w_illegal;
    w_bytes   = w_illegal ? 5'd16 : (5'd1 << ab.size_i);
    w_pgSum   = {1'b0, w_ea[PGBITS-1:0]} + c_PGW'(w_bytes);
    w_cross   = (w_pgSum > c_PGSIZE);
    // A crossing access starts within 16 bytes of the page end, so the
    // remaining byte count is the 5-bit two's complement of the low offset.
    w_len0    = 5'd0 - w_ea[4:0];
    ab.ready_o = (r_state == IDLE) && (!ab.valid_o || ab.ready_i);
    w_accept  = ab.valid_i && ab.ready_o && !ab.flush_i;
  end

  // Beat registers and split FSM; flush behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || ab.flush_i) begin
      r_state    <= IDLE;
      r_adr1     <= '0;
      r_len1     <= '0;
      ab.valid_o <= 1'b0;
      ab.id_o    <= '0;
      ab.adr_o   <= '0;
      ab.len_o   <= '0;
      ab.store_o <= 1'b0;
      ab.split_o <= 1'b0;
      ab.last_o  <= 1'b0;
      ab.excv_o  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            ab.valid_o <= 1'b1;
            ab.id_o    <= ab.id_i;
            ab.adr_o   <= w_ea;
            ab.store_o <= ab.store_i;
            ab.excv_o  <= w_exc;
            if (w_cross && !w_exc) begin
              ab.len_o   <= w_len0;
              ab.split_o <= 1'b1;
              ab.last_o  <= 1'b0;
              r_adr1     <= (w_ea | c_PGMASK) + AWID'(1);
              r_len1     <= w_bytes - w_len0;
              r_state    <= SPLIT;
            end else begin
              ab.len_o   <= w_bytes;
              ab.split_o <= 1'b0;
              ab.last_o  <= 1'b1;
            end
          end else if (ab.valid_o && ab.ready_i) begin
            ab.valid_o <= 1'b0;
          end
        end
        SPLIT: begin
          // Second beat only after the first has been taken.
          if (ab.ready_i) begin
            ab.adr_o   <= r_adr1;
            ab.len_o   <= r_len1;
            ab.split_o <= 1'b1;
            ab.last_o  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qupls_agen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qupls_agen_pipe
//  Description : Directed self-checking bench for qupls_agen_pipe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qupls_agen_pipe;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  qupls_agen_pipe_if #(.AWID(64), .IDW(5)) ab ();

  qupls_agen_pipe #(.AWID(64), .IDW(5), .PGBITS(12)) u_dut (
    .clk (clk),
    .rst (rst),
    .ab  (ab.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic [63:0] a, input logic [63:0] b, input logic [63:0] i,
                       input logic [1:0] sc, input logic [2:0] sz, input logic [4:0] id,
                       input logic st, input logic ex);
    ab.valid_i = 1'b1;
    ab.argA_i  = a;
    ab.argB_i  = b;
    ab.argI_i  = i;
    ab.scale_i = sc;
    ab.size_i  = sz;
    ab.id_i    = id;
    ab.store_i = st;
    ab.excv_i  = ex;
  endtask

  initial begin
    rst        = 1'b1;
    ab.flush_i = 1'b0;
    ab.valid_i = 1'b0;
    ab.ready_i = 1'b1;
    ab.id_i    = '0;
    ab.argA_i  = '0;
    ab.argB_i  = '0;
    ab.argI_i  = '0;
    ab.scale_i = '0;
    ab.size_i  = '0;
    ab.store_i = 1'b0;
    ab.excv_i  = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk("rst_valid", 64'(ab.valid_o), 64'd0);
    chk("rst_adr",   ab.adr_o,        64'd0);
    chk("rst_len",   64'(ab.len_o),   64'd0);
    chk("rst_last",  64'(ab.last_o),  64'd0);
    chk("rst_ready", 64'(ab.ready_o), 64'd1);
    rst = 1'b0;
    cyc();

    // 1: scaled index + negative displacement
    setop(64'h1000, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 3'd3, 5'd1, 1'b1, 1'b0);
    cyc();
    ab.valid_i = 1'b0;
    chk("t1_valid", 64'(ab.valid_o), 64'd1);
    chk("t1_adr",   ab.adr_o,        64'h1078);
    chk("t1_len",   64'(ab.len_o),   64'd8);
    chk("t1_last",  64'(ab.last_o),  64'd1);
    chk("t1_split", 64'(ab.split_o), 64'd0);
    chk("t1_id",    64'(ab.id_o),    64'd1);
    chk("t1_store", 64'(ab.store_o), 64'd1);
    cyc();
    chk("t1_drop",  64'(ab.valid_o), 64'd0);

    // 2: page-crossing access split into two beats
    setop(64'h1FFC, 64'h0, 64'h0, 2'd0, 3'd3, 5'd2, 1'b0, 1'b0);
    cyc();
    ab.valid_i = 1'b0;
    chk("t2_b0_adr",   ab.adr_o,        64'h1FFC);
    chk("t2_b0_len",   64'(ab.len_o),   64'd4);
    chk("t2_b0_last",  64'(ab.last_o),  64'd0);
    chk("t2_b0_split", 64'(ab.split_o), 64'd1);
    chk("t2_b0_ready", 64'(ab.ready_o), 64'd0);
    cyc();
    chk("t2_b1_valid", 64'(ab.valid_o), 64'd1);
    chk("t2_b1_adr",   ab.adr_o,        64'h2000);
    chk("t2_b1_len",   64'(ab.len_o),   64'd4);
    chk("t2_b1_last",  64'(ab.last_o),  64'd1);
    chk("t2_b1_split", 64'(ab.split_o), 64'd1);
    chk("t2_b1_id",    64'(ab.id_o),    64'd2);
    cyc();
    chk("t2_drop",     64'(ab.valid_o), 64'd0);

    // 3: consumer stall holds the beat steady
    ab.ready_i = 1'b0;
    setop(64'h3000, 64'h0, 64'h0, 2'd0, 3'd2, 5'd3, 1'b0, 1'b0);
    cyc();
    ab.valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_valid", 64'(ab.valid_o), 64'd1);
      chk("t3_adr",   ab.adr_o,        64'h3000);
      chk("t3_len",   64'(ab.len_o),   64'd4);
      chk("t3_id",    64'(ab.id_o),    64'd3);
      chk("t3_ready", 64'(ab.ready_o), 64'd0);
      cyc();
    end
    ab.ready_i = 1'b1;
    cyc();
    chk("t3_retire", 64'(ab.valid_o), 64'd0);

    // 4: address wrap, then back-to-back op ending exactly at page end
    setop(64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h10, 2'd0, 3'd0, 5'd4, 1'b0, 1'b0);
    cyc();
    chk("t4_wrap_adr",  ab.adr_o,        64'h8);
    chk("t4_wrap_len",  64'(ab.len_o),   64'd1);
    chk("t4_wrap_excv", 64'(ab.excv_o),  64'd0);
    chk("t4_b2b_ready", 64'(ab.ready_o), 64'd1);
    setop(64'h1FFF, 64'h0, 64'h0, 2'd0, 3'd0, 5'd6, 1'b0, 1'b0);
    cyc();
    ab.valid_i = 1'b0;
    chk("t4_b2b_valid", 64'(ab.valid_o), 64'd1);
    chk("t4_b2b_adr",   ab.adr_o,        64'h1FFF);
    chk("t4_b2b_split", 64'(ab.split_o), 64'd0);
    chk("t4_b2b_last",  64'(ab.last_o),  64'd1);
    chk("t4_b2b_id",    64'(ab.id_o),    64'd6);
    cyc();
    chk("t4_drop",      64'(ab.valid_o), 64'd0);

    // 5: flush while beat0 of a split access is stalled
    ab.ready_i = 1'b0;
    setop(64'h1FFC, 64'h0, 64'h0, 2'd0, 3'd3, 5'd5, 1'b0, 1'b0);
    cyc();
    chk("t5_b0_split", 64'(ab.split_o), 64'd1);
    setop(64'h500, 64'h0, 64'h0, 2'd0, 3'd0, 5'd7, 1'b0, 1'b0);
    ab.flush_i = 1'b1;
    cyc();
    ab.flush_i = 1'b0;
    ab.valid_i = 1'b0;
    ab.ready_i = 1'b1;
    chk("t5_fl_valid", 64'(ab.valid_o), 64'd0);
    chk("t5_fl_adr",   ab.adr_o,        64'd0);
    chk("t5_fl_ready", 64'(ab.ready_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t5_no_beat1", 64'(ab.valid_o), 64'd0);
    end

    // 6: incoming exception suppresses the split; illegal size
    setop(64'h2FF8, 64'h0, 64'h0, 2'd0, 3'd4, 5'd8, 1'b0, 1'b1);
    cyc();
    chk("t6_exc_excv",  64'(ab.excv_o),  64'd1);
    chk("t6_exc_adr",   ab.adr_o,        64'h2FF8);
    chk("t6_exc_len",   64'(ab.len_o),   64'd16);
    chk("t6_exc_split", 64'(ab.split_o), 64'd0);
    chk("t6_exc_last",  64'(ab.last_o),  64'd1);
    setop(64'h40, 64'h0, 64'h0, 2'd0, 3'd6, 5'd9, 1'b0, 1'b0);
    cyc();
    ab.valid_i = 1'b0;
    chk("t6_ill_excv",  64'(ab.excv_o),  64'd1);
    chk("t6_ill_len",   64'(ab.len_o),   64'd16);
    chk("t6_ill_split", 64'(ab.split_o), 64'd0);
    chk("t6_ill_adr",   ab.adr_o,        64'h40);
    cyc();
    chk("t6_drop",      64'(ab.valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
